// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the fetch port, the load/store port and the shared
// memory. The arbiter connects through the slave modport. The environment
// (requesters plus memory) drives it through the master modport.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    // Fetch port
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    // Load/store port
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    // Shared memory side
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    // Watchdog abort
    logic              err;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, err
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: shares one unified memory between the fetch path
// and the load/store path. It runs one transaction at a time and aborts it
// through a watchdog if the memory never acknowledges.
// Optional feature macro: ARB_ROUND_ROBIN_EN. When it is defined, simultaneous
// requests alternate between the ports. When it is undefined, data has fixed
// priority over fetch.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);
    localparam int unsigned WDOG_W = 8;
    // Counter value from which one more silent BUSY cycle reaches TIMEOUT
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } state_t;

    state_t              state;
    logic [WDOG_W-1:0]   wdog;
    logic                pick_d_c;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 when fetch was the most recent grant, so data wins the next tie
    logic                last_if;

    // Round-robin winner: only a tie consults the pointer
    always_comb begin
        pick_d_c = bus.d_req;
        if (bus.d_req && bus.if_req) begin
            pick_d_c = last_if;
        end
    end
`else
    // Fixed priority: data beats fetch whenever it is requesting
    always_comb begin
        pick_d_c = bus.d_req;
    end
`endif

    // Arbitration FSM with registered grants, memory command and responses
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            wdog          <= WDOG_W'(0);
            bus.if_gnt    <= 1'b0;
            bus.if_rvalid <= 1'b0;
            bus.if_rdata  <= DATA_W'(0);
            bus.d_gnt     <= 1'b0;
            bus.d_rvalid  <= 1'b0;
            bus.d_rdata   <= DATA_W'(0);
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= ADDR_W'(0);
            bus.mem_wdata <= DATA_W'(0);
            bus.err       <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_if       <= 1'b1;
`endif
        end else begin
            // Pulsed outputs default low every cycle
            bus.if_gnt    <= 1'b0;
            bus.d_gnt     <= 1'b0;
            bus.mem_req   <= 1'b0;
            bus.if_rvalid <= 1'b0;
            bus.d_rvalid  <= 1'b0;
            bus.err       <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.d_req || bus.if_req) begin
                        wdog        <= WDOG_W'(0);
                        bus.mem_req <= 1'b1;
                        if (pick_d_c) begin
                            bus.d_gnt     <= 1'b1;
                            bus.mem_we    <= bus.d_we;
                            bus.mem_addr  <= bus.d_addr;
                            bus.mem_wdata <= bus.d_wdata;
                            state         <= BUSY_D;
`ifdef ARB_ROUND_ROBIN_EN
                            last_if       <= 1'b0;
`endif
                        end else begin
                            bus.if_gnt    <= 1'b1;
                            bus.mem_we    <= 1'b0;
                            bus.mem_addr  <= bus.if_addr;
                            bus.mem_wdata <= DATA_W'(0);
                            state         <= BUSY_IF;
`ifdef ARB_ROUND_ROBIN_EN
                            last_if       <= 1'b1;
`endif
                        end
                    end
                end

                BUSY_IF: begin
                    if (bus.mem_ack) begin
                        bus.if_rdata  <= bus.mem_rdata;
                        bus.if_rvalid <= 1'b1;
                        state         <= IDLE;
                    end else if (wdog == WDOG_LAST) begin
                        bus.if_rdata  <= DATA_W'(0);
                        bus.if_rvalid <= 1'b1;
                        bus.err       <= 1'b1;
                        wdog          <= wdog + WDOG_W'(1);
                        state         <= IDLE;
                    end else begin
                        wdog          <= wdog + WDOG_W'(1);
                    end
                end

                BUSY_D: begin
                    if (bus.mem_ack) begin
                        // Stores complete with zero read data
                        bus.d_rdata   <= bus.mem_we ? DATA_W'(0) : bus.mem_rdata;
                        bus.d_rvalid  <= 1'b1;
                        state         <= IDLE;
                    end else if (wdog == WDOG_LAST) begin
                        bus.d_rdata   <= DATA_W'(0);
                        bus.d_rvalid  <= 1'b1;
                        bus.err       <= 1'b1;
                        wdog          <= wdog + WDOG_W'(1);
                        state         <= IDLE;
                    end else begin
                        wdog          <= wdog + WDOG_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Single-port memory arbiter that shares one unified instruction/data memory between the fetch path and the load/store path of the RISC-V core. It accepts requests from both ports and issues one transaction at a time to the memory. It holds that transaction until the memory acknowledges it, then returns the data to the winning port. Sits between program counter/fetch logic, the load/store datapath, and the shared memory macro; its grants also serve as the core's stall signals.

## Interface
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- TIMEOUT, 255, max cycles waiting for mem_ack before abort (1..255, 8-bit counter)

- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch read request, level
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch request accepted (1-cycle pulse)
- if_rvalid  out  1  fetch data valid (1-cycle pulse)
- if_rdata  out  DATA_W  fetch data
- d_req  in  1  data request, level
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data request accepted (1-cycle pulse)
- d_rvalid  out  1  load data valid / store complete (1-cycle pulse)
- d_rdata  out  DATA_W  load data (0 for stores)
- mem_req  out  1  memory command strobe (1-cycle pulse)
- mem_we  out  1  memory write enable, valid with mem_req
- mem_addr  out  ADDR_W  memory address, held until ack
- mem_wdata  out  DATA_W  memory write data, held until ack
- mem_ack  in  1  memory completion, 1-cycle pulse
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- err  out  1  timeout abort (1-cycle pulse)

## Operation
- FSM states: IDLE, BUSY_IF, BUSY_D.
- IDLE: sample if_req/d_req.
  - None asserted: stay in IDLE.
  - Otherwise pick a winner, latch its address/we/wdata into mem_* registers, and go to BUSY_IF or BUSY_D.
  - Fetch is always latched with mem_we=0.
- Arbitration (default): d_req has fixed priority over if_req.
- BUSY_x:
  - mem_ack=1: register mem_rdata into x_rdata, pulse x_rvalid, return to IDLE.
  - d_rdata is forced to 0 for stores.
- Watchdog: an 8-bit counter clears on entry to BUSY_x and increments each BUSY cycle without ack.
  - Counter reaching TIMEOUT: pulse err and x_rvalid with x_rdata=0, return to IDLE.
- Stray mem_ack (in IDLE, or in the cycle after a timeout abort): ignored; no output change.
- Commitment: a request sampled in IDLE is committed. Requesters hold req/addr/data until their gnt, and may change them from the cycle after gnt.
- Only one outstanding transaction; the losing port keeps req asserted and is served in the next IDLE.

## Timing
- Reset values: all outputs 0, state IDLE, watchdog 0, rr pointer = fetch-last.
- rst mid-transaction: abort next edge, no rvalid, no err; later mem_ack ignored.
- Request sampled in IDLE at edge N: x_gnt=1, mem_req=1 and mem_* valid during cycle N+1.
- mem_ack at cycle M (M ≥ N+1): x_rvalid/x_rdata during cycle M+1, state IDLE in M+1.
- Next arbitration at edge M+1 → next mem_req in M+2. Back-to-back throughput: one transaction per (memory latency + 2) cycles.
- mem_ack in the same cycle as mem_req (zero latency) is legal and is accepted.
- Timeout: err and x_rvalid pulse in the cycle after the counter reaches TIMEOUT.
- gnt, rvalid, mem_req and err are never high for more than 1 consecutive cycle per transaction.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - Round-robin on simultaneous requests; the port not granted most recently wins.
  - Pointer updates on each grant; reset value makes data win the first tie.
  - A single requester always wins regardless of pointer.
- ARB_ROUND_ROBIN_EN undefined: fixed data-over-fetch priority; no pointer state.

## Test plan
- Fetch only: if_req=1, if_addr=0x10, mem_ack 2 cycles after mem_req with rdata=0x00500093 → if_gnt 1 cycle after req; if_rvalid with 0x00500093 in the cycle after ack.
- Store then load: d_req, d_we=1, addr 0x100, wdata 0xDEADBEEF → mem_we=1 with that addr/data; d_rvalid with d_rdata=0. Then load 0x100, memory model returns 0xDEADBEEF → d_rdata=0xDEADBEEF.
- Contention: if_req and d_req both held for 4 transactions.
  - Default build: D,D,D,D while d_req stays high.
  - ARB_ROUND_ROBIN_EN build: D,IF,D,IF.
- Timeout: TIMEOUT=4, mem_ack never asserted → err and d_rvalid pulse once, d_rdata=0, state IDLE. A late mem_ack is ignored, with no rvalid.
- Reset mid-op: rst=1 while in BUSY_IF → all outputs 0 next cycle; a mem_ack the cycle after rst deasserts produces no if_rvalid.
- Zero-latency ack: mem_ack in the same cycle as mem_req → rvalid in the next cycle, new mem_req 2 cycles after ack.
